axis_master_vector_gen: RTL and testbench
=========================================

AXIS_MASTER_VECTOR_GEN -- requirements
Module: axis_master_vector_gen

Interface
REQ-001 The block SHALL have parameter NUM, default 4, giving the number of independent AXI-stream master lanes.
REQ-002 The block SHALL have parameter DSIZE, default 32, giving the tdata width in bits (minimum 16).
REQ-003 The block SHALL have parameter LEN_W, default 16, giving the width of the beat-count and frame-count fields.
REQ-004 The block SHALL have parameter GAP, default 2, giving the idle cycles inserted between consecutive frames on a lane.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all interface instances share it.
REQ-006 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, NUM bits: per-lane start pulse.
REQ-008 The block SHALL have port frame_len, input, LEN_W bits: beats per frame.
REQ-009 The block SHALL have port frame_num, input, LEN_W bits: frames per run.
REQ-010 The block SHALL have port seed, input, DSIZE-8 bits: first data value of each frame.
REQ-011 The block SHALL have port busy, output, NUM bits: lane run active.
REQ-012 The block SHALL have port done, output, NUM bits: one-cycle end-of-run pulse.
REQ-013 The block SHALL have port master [NUM-1:0], axi_stream_inf.master: generated streams.

Function
REQ-014 Each lane SHALL run an FSM IDLE -> SEND -> GAP -> SEND ... -> FIN -> IDLE, independent of the other lanes.
REQ-015 In IDLE, start[k]=1 SHALL latch frame_len, frame_num and seed into lane k, assert busy[k], and enter SEND on the next cycle.
REQ-016 start[k] while busy[k]=1 SHALL be ignored.
REQ-017 Input changes during a run SHALL NOT affect that run.
REQ-018 In SEND, axis_tvalid SHALL be 1.
REQ-019 tdata SHALL equal {k[7:0], seed + beat_index}, where beat_index starts at 0 for each frame and the low field wraps modulo 2^(DSIZE-8).
REQ-020 tdata and tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-021 The beat counter SHALL advance only on tvalid and tready both 1.
REQ-022 tlast SHALL be 1 exactly on beat frame_len-1.
REQ-023 A frame_len of 0 SHALL be treated as 1.
REQ-024 Acceptance of the last beat with frames remaining SHALL enter GAP; the lane SHALL hold tvalid=0 for exactly GAP cycles and then return to SEND.
REQ-025 With GAP=0, the lane SHALL go straight back to SEND, giving back-to-back frames.
REQ-026 Acceptance of the last beat of the last frame SHALL enter FIN; FIN SHALL pulse done[k] for one cycle, deassert busy[k], and return to IDLE.
REQ-027 A frame_num of 0 SHALL send no beats: start SHALL go to FIN directly, pulsing done exactly 2 cycles after start.
REQ-028 tkeep SHALL be driven all ones and tuser SHALL be driven 0.
REQ-029 The block SHALL have no combinational path from tready to tvalid.

Reset
REQ-030 aresetn=0 SHALL asynchronously force every lane to IDLE and drive tvalid, tlast, busy and done to 0 and the counters to 0, including mid-frame.
REQ-031 After reset release, a lane SHALL produce no output until a new start.

Structure
REQ-032 Package axis_gen_pkg SHALL hold the lane-state enum (IDLE, SEND, GAP, FIN) and the lane-ID field width constant of 8.
REQ-033 Sub-module axis_master_gen_lane SHALL implement one lane; the top SHALL be a generate loop over NUM instances.

Verification
REQ-034 Lane 0 with frame_len=4, frame_num=1, seed=0x10 and tready=1 SHALL give beats 0x00000010..0x00000013, tlast on the 4th beat, and done 1 cycle after.
REQ-035 Lane 2 with frame_len=3, frame_num=2, GAP=2 and tready=1 SHALL give 3 beats, exactly 2 idle cycles, then 3 beats, each frame starting from the seed.
REQ-036 Random tready backpressure on frame_len=8 SHALL give no data change while stalled, 8 accepted beats, and a single tlast.
REQ-037 Seed 0xFFFFFE with frame_len=4 SHALL give a low field of FFFFFE, FFFFFF, 000000, 000001.
REQ-038 frame_num=0 SHALL give no tvalid and a done pulse 2 cycles after start; start while busy SHALL leave the run unchanged.
REQ-039 aresetn=0 mid-frame with tready=0 SHALL drop tvalid immediately, and later starts SHALL restart cleanly from the seed.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// Shared types for the AXI-stream vector generator: lane FSM states and lane-ID width.
package axis_gen_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } lane_state_e;

endpackage

// File: rtl/axi_stream_inf.sv
// Minimal AXI-stream interface; the generator drives the master modport.
interface axi_stream_inf #(
    parameter int DSIZE = 32
) (
    input logic aclk,
    input logic aresetn
);
    logic               axis_tvalid;
    logic               axis_tready;
    logic [DSIZE-1:0]   axis_tdata;
    logic               axis_tlast;
    logic [DSIZE/8-1:0] axis_tkeep;
    logic               axis_tuser;

    modport master (
        input  aclk, aresetn, axis_tready,
        output axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser
    );

    modport slave (
        input  aclk, aresetn, axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser,
        output axis_tready
    );
endinterface

// File: rtl/axis_master_gen_lane.sv
// One generator lane: latches a run on start, emits frame_num frames of frame_len beats.
module axis_master_gen_lane
    import axis_gen_pkg::*;
#(
    parameter int               DSIZE   = 32,
    parameter int               LEN_W   = 16,
    parameter int               GAP_CYC = 2,
    parameter logic [ID_W-1:0]  LANE_ID = '0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic [LEN_W-1:0]      frame_num,
    input  logic [DSIZE-ID_W-1:0] seed,
    input  logic                  tready,
    output logic                  tvalid,
    output logic                  tlast,
    output logic [DSIZE-1:0]      tdata,
    output logic                  busy,
    output logic                  done
);
    localparam int DW = DSIZE - ID_W;

    lane_state_e      state;
    logic [LEN_W-1:0] len_q, num_q, beat_cnt, frame_cnt;
    logic [DW-1:0]    seed_q;
    logic [31:0]      gap_cnt;
    logic             last_beat, last_frame;

    assign last_beat  = (beat_cnt == len_q - LEN_W'(1));
    assign last_frame = (frame_cnt == num_q - LEN_W'(1));

    // Outputs come only from registers, so tready never reaches tvalid.
    assign tvalid = (state == ST_SEND);
    assign tlast  = tvalid && last_beat;
    assign tdata  = {LANE_ID, seed_q + DW'(beat_cnt)};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            num_q     <= '0;
            seed_q    <= '0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q     <= (frame_len == '0) ? LEN_W'(1) : frame_len;
                        num_q     <= frame_num;
                        seed_q    <= seed;
                        beat_cnt  <= '0;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= (frame_num == '0) ? ST_FIN : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tready) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (last_frame) begin
                                state <= ST_FIN;
                            end else begin
                                frame_cnt <= frame_cnt + LEN_W'(1);
                                gap_cnt   <= '0;
                                state     <= (GAP_CYC == 0) ? ST_SEND : ST_GAP;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 32'(GAP_CYC - 1)) state <= ST_SEND;
                    else                              gap_cnt <= gap_cnt + 32'd1;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/axis_master_vector_gen.sv
// NUM independent AXI-stream vector generators sharing one clock and reset.
module axis_master_vector_gen
    import axis_gen_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int DSIZE = 32,
    parameter int LEN_W = 16,
    parameter int GAP   = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM-1:0]        start,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic [LEN_W-1:0]      frame_num,
    input  logic [DSIZE-ID_W-1:0] seed,
    output logic [NUM-1:0]        busy,
    output logic [NUM-1:0]        done,
    axi_stream_inf.master         master [NUM-1:0]
);
    genvar k;
    generate
        for (k = 0; k < NUM; k++) begin : g_lane
            logic             tvalid, tlast;
            logic [DSIZE-1:0] tdata;

            axis_master_gen_lane #(
                .DSIZE   (DSIZE),
                .LEN_W   (LEN_W),
                .GAP_CYC (GAP),
                .LANE_ID (ID_W'(k))
            ) u_lane (
                .aclk      (aclk),
                .aresetn   (aresetn),
                .start     (start[k]),
                .frame_len (frame_len),
                .frame_num (frame_num),
                .seed      (seed),
                .tready    (master[k].axis_tready),
                .tvalid    (tvalid),
                .tlast     (tlast),
                .tdata     (tdata),
                .busy      (busy[k]),
                .done      (done[k])
            );

            assign master[k].axis_tvalid = tvalid;
            assign master[k].axis_tlast  = tlast;
            assign master[k].axis_tdata  = tdata;
            assign master[k].axis_tkeep  = '1;
            assign master[k].axis_tuser  = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_axis_master_vector_gen.sv
// Bench for axis_master_vector_gen: directed and random runs checked against a beat-list model.
module tb_axis_master_vector_gen;
    localparam int NUM   = 4;
    localparam int DSIZE = 32;
    localparam int LEN_W = 16;
    localparam int GAP   = 2;
    localparam int DW    = DSIZE - 8;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NUM-1:0]       start;
    logic [LEN_W-1:0]     frame_len, frame_num;
    logic [DW-1:0]        seed;
    logic [NUM-1:0]       busy, done;
    logic [NUM-1:0]       tready, tvalid, tlast, tuser;
    logic [NUM-1:0][DSIZE-1:0]   tdata;
    logic [NUM-1:0][DSIZE/8-1:0] tkeep;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 aclk = ~aclk;

    axi_stream_inf #(.DSIZE(DSIZE)) axis [NUM-1:0] (.aclk(aclk), .aresetn(aresetn));

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_mon
            assign axis[gi].axis_tready = tready[gi];
            assign tvalid[gi] = axis[gi].axis_tvalid;
            assign tlast[gi]  = axis[gi].axis_tlast;
            assign tdata[gi]  = axis[gi].axis_tdata;
            assign tkeep[gi]  = axis[gi].axis_tkeep;
            assign tuser[gi]  = axis[gi].axis_tuser;
        end
    endgenerate

    axis_master_vector_gen #(
        .NUM(NUM), .DSIZE(DSIZE), .LEN_W(LEN_W), .GAP(GAP)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .frame_len (frame_len),
        .frame_num (frame_num),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .master    (axis)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        cyc++;
    endtask

    // Expected beats are the flat list frame x beat of {lane, seed+beat}; timing is checked
    // against the protocol rules: GAP idle cycles between frames, done two cycles after the
    // final acceptance (or after start for an empty run), stable data while stalled.
    task automatic run_lane(input int ln, input int len, input int num, input logic [DW-1:0] sd,
                            input int stall_pct, input bit poke);
        logic [DSIZE-1:0] exp_d[$];
        bit               exp_l[$];
        logic [DSIZE-1:0] prev_d, d;
        logic             prev_l;
        logic [NUM-1:0]   others;
        bit               l, in_gap, prev_stall, fin;
        int               eff, start_cyc, last_acc, idle, guard;

        eff = (len == 0) ? 1 : len;
        for (int f = 0; f < num; f++)
            for (int b = 0; b < eff; b++) begin
                exp_d.push_back({ln[7:0], sd + DW'(b)});
                exp_l.push_back(b == eff - 1);
            end

        frame_len = LEN_W'(len);
        frame_num = LEN_W'(num);
        seed      = sd;
        start[ln] = 1'b1;
        start_cyc = cyc;
        step();
        start[ln] = 1'b0;
        frame_len = LEN_W'($urandom);
        frame_num = LEN_W'($urandom);
        seed      = DW'($urandom);
        chk("busy_after_start", busy[ln], 1);

        in_gap = 0; prev_stall = 0; fin = 0; last_acc = start_cyc; idle = 0; guard = 0;
        prev_d = '0; prev_l = 1'b0;
        while (!fin && guard < 4000) begin
            guard++;
            tready[ln] = ($urandom_range(99) >= stall_pct);
            start[ln]  = poke && (cyc == start_cyc + 3);
            others     = tvalid;
            others[ln] = 1'b0;
            chk("other_lanes_idle", others, 0);
            if (tvalid[ln]) begin
                if (prev_stall) begin
                    chk("stall_data", tdata[ln], prev_d);
                    chk("stall_last", tlast[ln], prev_l);
                end
                if (in_gap) begin
                    chk("gap_cycles", idle, GAP);
                    in_gap = 0;
                end
                if (tready[ln]) begin
                    prev_stall = 0;
                    if (exp_d.size() == 0) begin
                        chk("extra_beat", tdata[ln], 0);
                        chk("extra_beat_flag", 1, 0);
                    end else begin
                        d = exp_d.pop_front();
                        l = exp_l.pop_front();
                        chk("beat_data", tdata[ln], d);
                        chk("beat_last", tlast[ln], l);
                        if (l) begin
                            in_gap = 1; idle = 0; last_acc = cyc;
                        end
                    end
                end else begin
                    prev_stall = 1; prev_d = tdata[ln]; prev_l = tlast[ln];
                end
            end else begin
                if (prev_stall) chk("valid_dropped_while_stalled", 0, 1);
                prev_stall = 0;
                if (in_gap) idle++;
            end
            if (done[ln]) begin
                fin = 1;
                chk("done_latency", cyc - last_acc, 2);
                chk("busy_at_done", busy[ln], 0);
                chk("beats_missing", exp_d.size(), 0);
            end else begin
                chk("busy_during_run", busy[ln], 1);
            end
            step();
        end
        start[ln]  = 1'b0;
        tready[ln] = 1'b1;
        if (!fin) chk("done_timeout", 0, 1);
        chk("done_one_cycle", done[ln], 0);
        chk("busy_after_done", busy[ln], 0);
        chk("valid_after_done", tvalid[ln], 0);
    endtask

    initial begin
        aresetn   = 1'b0;
        start     = '0;
        tready    = '1;
        frame_len = '0;
        frame_num = '0;
        seed      = '0;
        repeat (3) step();
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tlast", tlast, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        aresetn = 1'b1;
        repeat (3) step();
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);
        chk("tkeep_ones", tkeep[0], 4'hF);
        chk("tuser_zero", tuser, 0);

        run_lane(0, 4, 1, 24'h000010, 0, 0);
        run_lane(2, 3, 2, DW'($urandom), 0, 0);
        run_lane(3, 8, 1, DW'($urandom), 50, 0);
        run_lane(1, 4, 1, 24'hFFFFFE, 0, 0);
        run_lane(0, 5, 0, DW'($urandom), 0, 0);
        run_lane(2, 4, 2, DW'($urandom), 30, 1);
        run_lane(3, 0, 3, DW'($urandom), 0, 0);
        for (int i = 0; i < 6; i++)
            run_lane($urandom_range(NUM-1), $urandom_range(10), $urandom_range(3),
                     DW'($urandom), $urandom_range(60), 0);

        // Reset in the middle of a stalled frame.
        tready[1] = 1'b0;
        frame_len = 16'd6;
        frame_num = 16'd1;
        seed      = 24'h00ABCD;
        start[1]  = 1'b1;
        step();
        start[1]  = 1'b0;
        step();
        step();
        chk("pre_reset_valid", tvalid[1], 1);
        chk("pre_reset_data", tdata[1], 32'h0100ABCD);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_reset_valid", tvalid[1], 0);
        chk("async_reset_busy", busy[1], 0);
        chk("async_reset_last", tlast[1], 0);
        step();
        aresetn   = 1'b1;
        tready[1] = 1'b1;
        repeat (4) begin
            step();
            chk("post_reset_quiet", tvalid, 0);
            chk("post_reset_busy", busy, 0);
        end
        run_lane(1, 5, 2, 24'h00ABCD, 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
